// File: rtl/put_pkg.sv
// Shared types and sizing for the put/op strobe sequencer.
package put_pkg;

    localparam int DW   = 8;
    localparam int OPW  = 4;
    localparam int NMAX = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUT  = 2'd1,
        OP   = 2'd2
    } put_state_t;

endpackage

// File: rtl/put_sequencer.sv
// Replays one accepted operation packet as putEn/value strobes followed by a single opEn/ALUOp strobe.
module put_sequencer
    import put_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           stall,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_nops,
    input  logic [OPW-1:0] req_op,
    input  logic [DW-1:0]  req_a,
    input  logic [DW-1:0]  req_b,
    input  logic [DW-1:0]  req_c,
    output logic           putEn,
    output logic [DW-1:0]  value,
    output logic           opEn,
    output logic [OPW-1:0] ALUOp,
    output logic           busy
);

    put_state_t     state_q;
    put_state_t     state_d;
    logic [1:0]     idx_q;
    logic [1:0]     idx_d;
    logic [1:0]     nops_q;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  slot_q [NMAX];
    logic           accept;
    logic           put_act;
    logic           op_act;
    logic [DW-1:0]  operand;

    always_comb begin
        req_ready = !reset && !flush && !stall && (state_q == IDLE || state_q == OP);
        accept    = req_valid && req_ready;
        put_act   = (state_q == PUT) && !stall && !flush;
        op_act    = (state_q == OP) && !stall && !flush;

        case (idx_q)
            2'd0:    operand = slot_q[0];
            2'd1:    operand = slot_q[1];
            default: operand = slot_q[2];
        endcase

        putEn = put_act;
        value = put_act ? operand : '0;
        opEn  = op_act;
        ALUOp = op_act ? op_q : '0;
        busy  = (state_q != IDLE);

        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = (req_nops != 2'd0) ? PUT : OP;
                        idx_d   = 2'd0;
                    end
                end
                PUT: begin
                    if (idx_q == nops_q - 2'd1) begin
                        state_d = OP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                OP: begin
                    // The op cycle doubles as the acceptance slot for the next packet.
                    idx_d = 2'd0;
                    if (accept) begin
                        state_d = (req_nops != 2'd0) ? PUT : OP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= 2'd0;
            nops_q <= 2'd0;
            op_q   <= '0;
            for (int i = 0; i < NMAX; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            if (accept) begin
                nops_q    <= req_nops;
                op_q      <= req_op;
                slot_q[0] <= req_a;
                slot_q[1] <= req_b;
                slot_q[2] <= req_c;
            end
        end
    end

endmodule

// File: tb/tb_put_sequencer.sv
// Bench for put_sequencer: queue-of-pending-strobes reference model plus directed literal checks.
module tb_put_sequencer;
    import put_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           stall;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_nops;
    logic [OPW-1:0] req_op;
    logic [DW-1:0]  req_a;
    logic [DW-1:0]  req_b;
    logic [DW-1:0]  req_c;
    logic           putEn;
    logic [DW-1:0]  value;
    logic           opEn;
    logic [OPW-1:0] ALUOp;
    logic           busy;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    // Pending strobes in issue order: 0..255 is a put of that value, 256+op is the operate strobe.
    int pend[$];

    always #5 clk = ~clk;

    put_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_nops(req_nops),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .putEn(putEn), .value(value), .opEn(opEn), .ALUOp(ALUOp), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int  front;
        bit  has;
        bit  go;
        if (chk_on) begin
            has   = (pend.size() > 0);
            front = has ? pend[0] : 0;
            go    = !stall && !flush;
            check("model_putEn", putEn, go && has && front < 256);
            check("model_value", value, (go && has && front < 256) ? front : 0);
            check("model_opEn", opEn, go && has && front >= 256);
            check("model_ALUOp", ALUOp, (go && has && front >= 256) ? front - 256 : 0);
            check("model_busy", busy, has);
            check("model_ready", req_ready, !reset && go && (!has || front >= 256));
        end
    end

    always @(posedge clk) begin
        int front;
        bit rdy;
        front = (pend.size() > 0) ? pend[0] : -1;
        rdy   = !reset && !flush && !stall && (pend.size() == 0 || front >= 256);
        if (reset || flush) begin
            pend.delete();
        end else if (!stall) begin
            if (pend.size() > 0) void'(pend.pop_front());
            if (req_valid && rdy) begin
                if (req_nops > 0) pend.push_back(int'(req_a));
                if (req_nops > 1) pend.push_back(int'(req_b));
                if (req_nops > 2) pend.push_back(int'(req_c));
                pend.push_back(256 + int'(req_op));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input int n, input int op, input int a, input int b, input int c);
        req_valid = 1'b1;
        req_nops  = 2'(n);
        req_op    = OPW'(op);
        req_a     = DW'(a);
        req_b     = DW'(b);
        req_c     = DW'(c);
    endtask

    task automatic exp_out(input string name, input int pe, input int val, input int oe, input int op);
        check({name, "_putEn"}, putEn, pe);
        check({name, "_value"}, value, val);
        check({name, "_opEn"}, opEn, oe);
        check({name, "_ALUOp"}, ALUOp, op);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0; req_valid = 1'b0;
        req_nops = '0; req_op = '0; req_a = '0; req_b = '0; req_c = '0;

        // 1: reset for two cycles, then idle and ready
        cyc();
        chk_on = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        exp_out("t1", 0, 0, 0, 0);
        check("t1_busy", busy, 0);
        check("t1_ready", req_ready, 1);

        // 2: three-operand packet
        drive_pkt(3, 'h2, 'h11, 'h22, 'h33);
        cyc(); req_valid = 1'b0; #2; exp_out("t2_p0", 1, 'h11, 0, 0);
        cyc(); #2; exp_out("t2_p1", 1, 'h22, 0, 0);
        cyc(); #2; exp_out("t2_p2", 1, 'h33, 0, 0);
        cyc(); #2; exp_out("t2_op", 0, 0, 1, 'h2);
        cyc(); #2; check("t2_busy", busy, 0);

        // 3: zero-operand packet
        drive_pkt(0, 'h5, 'h99, 'h98, 'h97);
        cyc(); req_valid = 1'b0; #2; exp_out("t3_op", 0, 0, 1, 'h5);
        cyc(); #2; exp_out("t3_after", 0, 0, 0, 0);
        check("t3_busy", busy, 0);

        // 4: back-to-back packets
        drive_pkt(1, 'h3, 'hAA, 0, 0);
        cyc(); drive_pkt(2, 'h7, 'h01, 'h02, 0);
        #2; exp_out("t4_pAA", 1, 'hAA, 0, 0);
        check("t4_ready_put", req_ready, 0);
        cyc(); #2; exp_out("t4_op1", 0, 0, 1, 'h3);
        check("t4_ready_op", req_ready, 1);
        cyc(); req_valid = 1'b0; #2; exp_out("t4_p01", 1, 'h01, 0, 0);
        cyc(); #2; exp_out("t4_p02", 1, 'h02, 0, 0);
        cyc(); #2; exp_out("t4_op2", 0, 0, 1, 'h7);
        cyc(); #2; check("t4_busy", busy, 0);

        // 5: stall two cycles after the first put
        drive_pkt(3, 'h9, 'hA1, 'hB2, 'hC3);
        cyc(); req_valid = 1'b0; #2; exp_out("t5_pA1", 1, 'hA1, 0, 0);
        cyc(); stall = 1'b1; #2; exp_out("t5_st0", 0, 0, 0, 0);
        check("t5_busy", busy, 1);
        cyc(); #2; exp_out("t5_st1", 0, 0, 0, 0);
        cyc(); stall = 1'b0; #2; exp_out("t5_pB2", 1, 'hB2, 0, 0);
        cyc(); #2; exp_out("t5_pC3", 1, 'hC3, 0, 0);
        cyc(); #2; exp_out("t5_op", 0, 0, 1, 'h9);
        cyc(); #2; check("t5_busy_end", busy, 0);

        // 6: flush during second put, then reset during an op cycle
        drive_pkt(3, 'h6, 'h44, 'h55, 'h66);
        cyc(); req_valid = 1'b0; #2; exp_out("t6_p44", 1, 'h44, 0, 0);
        cyc(); flush = 1'b1; #2; exp_out("t6_flush", 0, 0, 0, 0);
        cyc(); flush = 1'b0; #2; exp_out("t6_after", 0, 0, 0, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", req_ready, 1);
        cyc(); #2; exp_out("t6_noop", 0, 0, 0, 0);

        drive_pkt(1, 'h4, 'h77, 0, 0);
        cyc(); req_valid = 1'b0; #2; exp_out("t6r_p77", 1, 'h77, 0, 0);
        cyc(); #2; exp_out("t6r_op", 0, 0, 1, 'h4);
        reset = 1'b1;
        cyc(); #2; exp_out("t6r_rst", 0, 0, 0, 0);
        check("t6r_busy", busy, 0);
        check("t6r_ready", req_ready, 0);
        reset = 1'b0;
        #1; check("t6r_ready_rel", req_ready, 1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset     = ($urandom_range(0, 249) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            stall     = ($urandom_range(0, 6) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_nops  = 2'($urandom_range(0, 3));
            req_op    = OPW'($urandom);
            req_a     = DW'($urandom);
            req_b     = DW'($urandom);
            req_c     = DW'($urandom);
        end
        cyc();
        reset = 1'b0; flush = 1'b0; stall = 1'b0; req_valid = 1'b0;
        repeat (6) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
